// File: rtl/dcm_24mhz_pkg.sv
// Shared constants and elaboration helpers for the dcm_24mhz clock synthesizer.
// Optional feature macro: DCM_24MHZ_GATE_UNTIL_LOCK_EN (holds the output low until locked).
package dcm_24mhz_pkg;

   localparam int unsigned DEF_CLK_IN_HZ   = 50_000_000;
   localparam int unsigned DEF_CLK_OUT_HZ  = 24_000_000;
   localparam int unsigned DEF_LOCK_CYCLES = 16;
   localparam int unsigned LOCK_CNT_W      = 16;

   typedef enum logic [0:0] {
      LOCK_WAIT = 1'b0,
      LOCK_DONE = 1'b1
   } lock_state_e;

   // Euclid's algorithm, usable as a constant function at elaboration.
   function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
      int unsigned x;
      int unsigned y;
      int unsigned t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Toggles per MOD input cycles: two toggles make one output period.
   function automatic int unsigned calc_inc(input int unsigned in_hz, input int unsigned out_hz);
      return (2 * out_hz) / gcd(2 * out_hz, in_hz);
   endfunction

   // Reduced input-cycle modulus.
   function automatic int unsigned calc_mod(input int unsigned in_hz, input int unsigned out_hz);
      return in_hz / gcd(2 * out_hz, in_hz);
   endfunction

   // Accumulator width; a modulus of 1 still needs one storage bit.
   function automatic int unsigned acc_width(input int unsigned modulus);
      return (modulus <= 1) ? 1 : int'($clog2(modulus));
   endfunction

   localparam int unsigned DEF_INC = calc_inc(DEF_CLK_IN_HZ, DEF_CLK_OUT_HZ);
   localparam int unsigned DEF_MOD = calc_mod(DEF_CLK_IN_HZ, DEF_CLK_OUT_HZ);

endpackage

// File: rtl/dcm_24mhz_phase_accum.sv
// Fractional phase accumulator: pulses tick on each modulus overflow.
module phase_accum
   import dcm_24mhz_pkg::*;
#(
   parameter int unsigned INC = DEF_INC,
   parameter int unsigned MOD = DEF_MOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned AW = acc_width(MOD);
   localparam int unsigned SW = AW + 1;

   logic [AW-1:0] acc_q;
   logic [AW-1:0] acc_d;
   logic [SW-1:0] sum_c;
   logic          ovf_c;

   // Next accumulator value; overflow is decided on the same edge it is consumed.
   always_comb begin
      sum_c = {1'b0, acc_q} + SW'(INC);
      ovf_c = en && (sum_c >= SW'(MOD));
      acc_d = acc_q;
      if (ovf_c) begin
         acc_d = AW'(sum_c - SW'(MOD));
      end else if (en) begin
         acc_d = AW'(sum_c);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign tick = ovf_c;

endmodule

// File: rtl/dcm_24mhz.sv
// Camera XCLK synthesizer: fractional accumulator drives a single toggle flop.
// Optional feature macro: DCM_24MHZ_GATE_UNTIL_LOCK_EN (accumulator and XCLK held until locked).
module dcm_24mhz
   import dcm_24mhz_pkg::*;
#(
   parameter int unsigned CLK_IN_HZ   = DEF_CLK_IN_HZ,
   parameter int unsigned CLK_OUT_HZ  = DEF_CLK_OUT_HZ,
   parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   output logic cmos_xclk,
   output logic locked
);

   localparam int unsigned INC = calc_inc(CLK_IN_HZ, CLK_OUT_HZ);
   localparam int unsigned MOD = calc_mod(CLK_IN_HZ, CLK_OUT_HZ);

   // Reject ratios the single toggle flop cannot produce.
   if ((2 * CLK_OUT_HZ) > CLK_IN_HZ) begin : g_bad_ratio
      $error("dcm_24mhz: 2*CLK_OUT_HZ must not exceed CLK_IN_HZ");
   end
   if (CLK_OUT_HZ == 0) begin : g_bad_out
      $error("dcm_24mhz: CLK_OUT_HZ must be non-zero");
   end
   if ((LOCK_CYCLES < 1) || (LOCK_CYCLES > 65535)) begin : g_bad_lock
      $error("dcm_24mhz: LOCK_CYCLES must be in 1..65535");
   end

   lock_state_e           state_q;
   lock_state_e           state_d;
   logic [LOCK_CNT_W-1:0] cnt_q;
   logic [LOCK_CNT_W-1:0] cnt_d;
   logic                  locked_q;
   logic                  xclk_q;
   logic                  accum_en;
   logic                  tick;

`ifdef DCM_24MHZ_GATE_UNTIL_LOCK_EN
   assign accum_en = locked_q;
`else
   assign accum_en = 1'b1;
`endif

   phase_accum #(
      .INC (INC),
      .MOD (MOD)
   ) u_phase_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accum_en),
      .tick  (tick)
   );

   // Lock state register and counter; locked is registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LOCK_WAIT;
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         locked_q <= (state_d == LOCK_DONE);
      end
   end

   // Lock next-state: count posedges until LOCK_CYCLES, then stick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LOCK_WAIT: begin
            cnt_d = cnt_q + LOCK_CNT_W'(1);
            if (cnt_q == LOCK_CNT_W'(LOCK_CYCLES - 1)) begin
               state_d = LOCK_DONE;
            end
         end
         LOCK_DONE: begin
            state_d = LOCK_DONE;
         end
         default: begin
            state_d = LOCK_WAIT;
         end
      endcase
   end

   // XCLK toggle flop, flips on every accumulator overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xclk_q <= 1'b0;
      end else if (tick) begin
         xclk_q <= ~xclk_q;
      end
   end

   assign cmos_xclk = xclk_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_dcm_24mhz.sv
// Scoreboard bench for dcm_24mhz: defaults instance plus a 25 MHz (divide-by-2) instance.
`timescale 1ns/1ps
module tb_dcm_24mhz;

`ifdef DCM_24MHZ_GATE_UNTIL_LOCK_EN
   localparam bit GATED = 1'b1;
`else
   localparam bit GATED = 1'b0;
`endif
   localparam int LOCK = 16;

   typedef struct {
      int   p;
      logic x;
      logic l;
      logic x2;
   } exp_t;

   logic clk;
   logic rst_n;
   logic cmos_xclk;
   logic locked;
   logic cmos_xclk2;
   logic locked2;

   exp_t sb[$];
   int   n_checks;
   int   n_pass;

   // Bench-side expectation state.
   int   p;
   int   n;
   logic xe;
   logic xe2;

   // Waveform statistics.
   logic prev_x;
   int   rise_cnt;
   int   hold_cnt;
   int   runlen;
   bit   run_started;

   dcm_24mhz u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmos_xclk (cmos_xclk),
      .locked    (locked)
   );

   dcm_24mhz #(
      .CLK_OUT_HZ (25_000_000)
   ) u_dut25 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmos_xclk (cmos_xclk2),
      .locked    (locked2)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input int pp, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s p=%0d actual=%0d required=%0d", name, pp, act, req);
   endtask

   // Monitor: pops one expectation per cycle and compares against the DUT.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("xclk",    e.p, int'(cmos_xclk),  int'(e.x));
         chk("locked",  e.p, int'(locked),     int'(e.l));
         chk("xclk25",  e.p, int'(cmos_xclk2), int'(e.x2));
         chk("locked25", e.p, int'(locked2),   int'(e.l));
      end
   end

   task automatic model_reset();
      p   = 0;
      n   = 0;
      xe  = 1'b0;
      xe2 = 1'b0;
   endtask

   // One clock under reset: everything must stay at zero.
   task automatic step_rst();
      exp_t e;
      @(posedge clk);
      e.p = -1; e.x = 1'b0; e.l = 1'b0; e.x2 = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      prev_x = cmos_xclk;
   endtask

   // One running clock: advance expectation, push it, then gather statistics.
   task automatic step();
      exp_t e;
      bit   active;
      bit   changed;
      @(posedge clk);
      p++;
      active = GATED ? (p >= LOCK + 1) : 1'b1;
      if (active) begin
         n++;
         // The acc=0 edge (first of each 25) is the only one without overflow.
         if ((n % 25) != 1) xe = ~xe;
         xe2 = ~xe2;
      end
      e.p = p; e.x = xe; e.l = (p >= LOCK); e.x2 = xe2;
      sb.push_back(e);
      @(negedge clk);
      changed = (cmos_xclk != prev_x);
      if (p >= 41 && p <= 2540) begin
         if (cmos_xclk && !prev_x) rise_cnt++;
      end
      if (p >= 41 && p <= 290) begin
         if (!changed) hold_cnt++;
         if (changed) begin
            if (run_started) chk("half_period_len", p, (runlen >= 1 && runlen <= 2) ? 1 : 0, 1);
            run_started = 1'b1;
            runlen      = 1;
         end else begin
            runlen++;
         end
      end
      prev_x = cmos_xclk;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rise_cnt    = 0;
      hold_cnt    = 0;
      runlen      = 0;
      run_started = 1'b0;
      prev_x      = 1'b0;
      model_reset();
      rst_n = 1'b0;
      #5;
      chk("reset_xclk",   0, int'(cmos_xclk),  0);
      chk("reset_locked", 0, int'(locked),     0);
      chk("reset_xclk25", 0, int'(cmos_xclk2), 0);
      for (int i = 0; i < 3; i++) step_rst();
      rst_n = 1'b1;

      for (int i = 0; i < 2545; i++) step();
      chk("rises_2500", p, rise_cnt, 1200);
      chk("holds_250",  p, hold_cnt, 10);

      // Find a high phase, then reset asynchronously between edges.
      for (int i = 0; i < 4 && !cmos_xclk; i++) step();
      chk("xclk_high_before_reset", p, int'(cmos_xclk), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_xclk",   p, int'(cmos_xclk),  0);
      chk("async_rst_locked", p, int'(locked),     0);
      chk("async_rst_xclk25", p, int'(cmos_xclk2), 0);
      for (int i = 0; i < 3; i++) step_rst();
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) step();

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", p, sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
